capture_controller: RTL and testbench

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

---
 rtl/capture_controller_pkg.sv | 22 ++
 rtl/capture_controller_if.sv | 48 ++++
 rtl/capture_controller_addr_counter.sv | 52 +++++
 rtl/capture_controller.sv | 187 ++++++++++++++++++
 tb/tb_capture_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_controller_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Purpose : shared types and helpers for the capture controller slice.
//           - state_t  : capture FSM states
//           - depth_of : buffer depth for a given address width
// Ports   : none (package)
// -----------------------------------------------------------------------------
package capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } state_t;

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage : capture_pkg

// File: rtl/capture_controller_if.sv
// -----------------------------------------------------------------------------
// capture_controller_if
// Purpose : groups the sample stream, control pulses, configuration, buffer
//           write port and status flags of the capture controller.
// Ports   : master - drives valid/dataIn/arm/abort/trig/preTrigDepth/
//                    postTrigDepth/timeoutCycles, observes the rest
//           slave  - the controller side (inverse directions)
// -----------------------------------------------------------------------------
interface capture_controller_if #(
   parameter int SAMPLE_WIDTH  = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int TIMEOUT_WIDTH = 24
);
   // sample stream and control
   logic                     valid;
   logic [SAMPLE_WIDTH-1:0]  dataIn;
   logic                     arm;
   logic                     abort;
   logic                     trig;
   logic [ADDR_WIDTH-1:0]    preTrigDepth;
   logic [ADDR_WIDTH-1:0]    postTrigDepth;
   logic [TIMEOUT_WIDTH-1:0] timeoutCycles;
   // buffer write port
   logic                     mem_we;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [SAMPLE_WIDTH-1:0]  mem_data;
   // status
   logic                     busy;
   logic                     done;
   logic                     timed_out;
   logic [ADDR_WIDTH-1:0]    trig_addr;
   logic [ADDR_WIDTH-1:0]    start_addr;

   modport master (
      output valid, dataIn, arm, abort, trig,
             preTrigDepth, postTrigDepth, timeoutCycles,
      input  mem_we, mem_addr, mem_data,
             busy, done, timed_out, trig_addr, start_addr
   );

   modport slave (
      input  valid, dataIn, arm, abort, trig,
             preTrigDepth, postTrigDepth, timeoutCycles,
      output mem_we, mem_addr, mem_data,
             busy, done, timed_out, trig_addr, start_addr
   );

endinterface : capture_controller_if

// File: rtl/capture_controller_addr_counter.sv
// -----------------------------------------------------------------------------
// capture_addr_counter
// Purpose : wrapping buffer write address plus a per-phase sample counter
//           with a "this sample completes the phase" compare.
// Ports   : clock, reset     - clock, synchronous active-high reset
//           i_clear          - restart: address and count to 0
//           i_step           - a sample is written this cycle
//           i_seed_en/i_seed - this step opens a new phase; count restarts
//                              at i_seed (0 or 1) instead of incrementing
//           i_target         - samples in the current phase
//           o_addr           - address the current sample is written to
//           o_hit            - current sample is the last of the phase
// -----------------------------------------------------------------------------
module capture_addr_counter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_clear,
   input  logic                  i_step,
   input  logic                  i_seed_en,
   input  logic                  i_seed,
   input  logic [ADDR_WIDTH-1:0] i_target,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_hit
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   addr_t r_addr;
   addr_t r_count;
   addr_t w_count_inc;

   assign w_count_inc = r_count + addr_t'(1);
   // r_count holds samples already written in this phase, so the current
   // sample closes the phase when count+1 reaches the target.
   assign o_hit       = i_step && (w_count_inc == i_target);
   assign o_addr      = r_addr;

   // NOTE: sequential state is always assigned with <= so every register
   // samples the pre-edge values of its inputs, independent of block order.
   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_addr  <= '0;
         r_count <= '0;
      end else if (i_step) begin
         r_addr  <= r_addr + addr_t'(1);  // wraps modulo DEPTH by width
         r_count <= i_seed_en ? addr_t'(i_seed) : w_count_inc;
      end
   end

endmodule : capture_addr_counter

// File: rtl/capture_controller.sv
// -----------------------------------------------------------------------------
// capture_controller
// Purpose : pre/post-trigger capture into a circular buffer. After arm, the
//           first pre_eff valid samples are written (PRE), then writing
//           continues with wrap (WAIT) until a trig rising edge, then
//           post_eff samples starting with the trigger sample (POST), then
//           DONE with trig_addr/start_addr describing the capture window.
// Ports   : clock, reset - sole clock, synchronous active-high reset
//           bus (slave)  - valid/dataIn sample stream, arm/abort pulses,
//                          trig level, pre/post depths, timeoutCycles,
//                          mem_we/mem_addr/mem_data write port,
//                          busy/done/timed_out/trig_addr/start_addr status
// Options : CAPTURE_TIMEOUT_EN - forced trigger after timeoutCycles WAIT
//           samples (0 disables); without it timed_out is tied 0.
// -----------------------------------------------------------------------------
module capture_controller
   import capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH  = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int TIMEOUT_WIDTH = 24
) (
   input logic                 clock,
   input logic                 reset,
   capture_controller_if.slave bus
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [ADDR_WIDTH:0]   addr_ext_t;

   localparam addr_ext_t DEPTH_EXT = addr_ext_t'(depth_of(ADDR_WIDTH));

   state_t                  r_state;
   state_t                  w_next_state;
   addr_t                   r_pre_eff;
   addr_t                   r_post_eff;
   logic                    r_trig_prev;
   logic                    r_mem_we;
   addr_t                   r_mem_addr;
   logic [SAMPLE_WIDTH-1:0] r_mem_data;
   addr_t                   r_trig_addr;
   addr_t                   r_start_addr;

   addr_t                   w_post_eff;
   addr_ext_t               w_pre_room;
   addr_t                   w_pre_eff;
   logic                    w_capturing;
   logic                    w_write;
   logic                    w_edge;
   logic                    w_to_hit;
   logic                    w_trigger;
   logic                    w_seed_en;
   addr_t                   w_target;
   addr_t                   w_addr;
   logic                    w_cnt_hit;

   // Effective depths latched at arm: at least one post sample, and the
   // pre window shrinks so pre+post never exceeds the buffer.
   assign w_post_eff = (bus.postTrigDepth == '0) ? addr_t'(1) : bus.postTrigDepth;
   assign w_pre_room = DEPTH_EXT - {1'b0, w_post_eff};
   assign w_pre_eff  = ({1'b0, bus.preTrigDepth} < w_pre_room) ? bus.preTrigDepth
                                                               : w_pre_room[ADDR_WIDTH-1:0];

   // Edge is relative to trig as seen on the previous valid cycle, so gaps
   // in valid cannot create or hide an edge.
   assign w_edge = bus.valid && bus.trig && !r_trig_prev;

   capture_addr_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_counter (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (bus.arm),
      .i_step    (w_write),
      .i_seed_en (w_seed_en),
      .i_seed    (w_trigger),
      .i_target  (w_target),
      .o_addr    (w_addr),
      .o_hit     (w_cnt_hit)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_capturing  = 1'b0;
      w_write      = 1'b0;
      w_trigger    = 1'b0;
      w_seed_en    = 1'b0;
      w_target     = r_post_eff;

      w_capturing = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
      // Cycles carrying arm or abort never write: they end the old capture.
      w_write     = w_capturing && bus.valid && !bus.arm && !bus.abort;
      w_trigger   = (r_state == ST_WAIT) && w_write && (w_edge || w_to_hit);
      if (r_state == ST_PRE) w_target = r_pre_eff;
      // Count restarts at 0 entering WAIT, at 1 entering POST (the trigger
      // sample is the first post sample).
      w_seed_en   = ((r_state == ST_PRE) && w_cnt_hit) || w_trigger;

      if (bus.arm) begin
         w_next_state = (w_pre_eff == '0) ? ST_WAIT : ST_PRE;
      end else if (bus.abort) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_PRE:  if (w_cnt_hit) w_next_state = ST_WAIT;
            ST_WAIT: if (w_trigger) w_next_state = (r_post_eff == addr_t'(1)) ? ST_DONE : ST_POST;
            ST_POST: if (w_cnt_hit) w_next_state = ST_DONE;
            default: w_next_state = r_state;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pre_eff    <= '0;
         r_post_eff   <= '0;
         r_trig_prev  <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_trig_addr  <= '0;
         r_start_addr <= '0;
      end else begin
         if (bus.valid) r_trig_prev <= bus.trig;
         r_mem_we <= w_write;
         if (w_write) begin
            r_mem_addr <= w_addr;
            r_mem_data <= bus.dataIn;
         end
         if (bus.arm) begin
            r_pre_eff    <= w_pre_eff;
            r_post_eff   <= w_post_eff;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
         end else if (w_trigger) begin
            r_trig_addr  <= w_addr;
            r_start_addr <= w_addr - r_pre_eff;  // wraps modulo DEPTH
         end
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
   logic                     r_timed_out;

   // Current WAIT sample is number r_to_cnt+1; it is forced to be the
   // trigger when that equals a nonzero timeoutCycles.
   assign w_to_hit = (r_state == ST_WAIT) && w_write && (bus.timeoutCycles != '0)
                     && ((r_to_cnt + 1'b1) == bus.timeoutCycles);

   always_ff @(posedge clock) begin
      if (reset || bus.arm) begin
         r_to_cnt    <= '0;
         r_timed_out <= 1'b0;
      end else begin
         if ((r_state == ST_WAIT) && w_write) r_to_cnt <= r_to_cnt + 1'b1;
         if (w_to_hit && !w_edge)             r_timed_out <= 1'b1;
      end
   end

   assign bus.timed_out = r_timed_out;
`else
   logic w_unused_timeout;

   assign w_to_hit         = 1'b0;
   assign w_unused_timeout = ^bus.timeoutCycles;
   assign bus.timed_out    = 1'b0;
`endif

   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_data   = r_mem_data;
   assign bus.busy       = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
   assign bus.done       = (r_state == ST_DONE);
   assign bus.trig_addr  = r_trig_addr;
   assign bus.start_addr = r_start_addr;

endmodule : capture_controller

// File: tb/tb_capture_controller.sv
// -----------------------------------------------------------------------------
// tb_capture_controller
// Purpose : randomized self-checking bench for capture_controller
//           (ADDR_WIDTH=4, DEPTH=16). Each capture is described as a stream
//           of valid samples; the reference model finds the trigger sample
//           from the capture rules and derives the full expected write list.
// Options : CAPTURE_TIMEOUT_EN - also models the forced trigger.
// -----------------------------------------------------------------------------
module tb_capture_controller;

   localparam int SW    = 8;
   localparam int AW    = 4;
   localparam int TW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int NS    = 80;
`ifdef CAPTURE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   capture_controller_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) bus ();

   capture_controller #(
      .SAMPLE_WIDTH  (SW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write monitor: each buffer write recorded as (addr << 8) | data.
   int got_q[$];
   always @(negedge clock) begin
      if (bus.mem_we === 1'b1) got_q.push_back((int'(bus.mem_addr) << 8) | int'(bus.mem_data));
   end

   // Sample stream of one capture, indexed by valid-sample number after arm.
   bit          trig_s[NS];
   logic [SW-1:0] data_s[NS];

   // Reference: first sample at or after the pre window whose trig rises
   // relative to the previous sample (or where the WAIT sample count reaches
   // a nonzero timeout) is the trigger; -1 if none.
   function automatic void model(input int pre, input int post, input int tmo,
                                 output int k, output bit by_to,
                                 output int pre_eff, output int post_eff);
      bit e_hit;
      bit t_hit;
      post_eff = (post == 0) ? 1 : post;
      pre_eff  = (pre < DEPTH - post_eff) ? pre : DEPTH - post_eff;
      k        = -1;
      by_to    = 1'b0;
      for (int i = pre_eff; i < NS && k < 0; i++) begin
         e_hit = trig_s[i] && !((i == 0) ? 1'b0 : trig_s[i-1]);
         t_hit = TMO_EN && (tmo != 0) && (i - pre_eff + 1 == tmo);
         if (e_hit || t_hit) begin
            k     = i;
            by_to = !e_hit;
         end
      end
   endfunction

   task automatic idle_inputs();
      bus.valid         = 1'b0;
      bus.dataIn        = '0;
      bus.arm           = 1'b0;
      bus.abort         = 1'b0;
      bus.trig          = 1'b0;
      bus.preTrigDepth  = '0;
      bus.postTrigDepth = '0;
      bus.timeoutCycles = '0;
   endtask

   task automatic arm_cycle(input int pre, input int post, input int tmo);
      bus.preTrigDepth  = AW'(pre);
      bus.postTrigDepth = AW'(post);
      bus.timeoutCycles = TW'(tmo);
      bus.arm    = 1'b1;
      bus.valid  = 1'b1;
      bus.trig   = 1'b0;
      bus.dataIn = SW'($urandom);
      @(negedge clock);
      bus.arm    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"},       bus.busy,       0);
      check({tag, " done"},       bus.done,       0);
      check({tag, " timed_out"},  bus.timed_out,  0);
      check({tag, " mem_we"},     bus.mem_we,     0);
      check({tag, " mem_addr"},   bus.mem_addr,   0);
      check({tag, " trig_addr"},  bus.trig_addr,  0);
      check({tag, " start_addr"}, bus.start_addr, 0);
   endtask

   // mode: 0 valid always, 1 valid toggles 1/0, 2 valid random (trig random
   // on idle cycles too). Caller fills trig_s.
   task automatic run_capture(input string tag, input int pre, input int post, input int tmo,
                              input int mode, input int max_cycles);
      int k, pre_eff, post_eff, n_exp, i, cyc;
      bit by_to, v;
      for (int j = 0; j < NS; j++) data_s[j] = SW'($urandom);
      model(pre, post, tmo, k, by_to, pre_eff, post_eff);
      got_q.delete();
      arm_cycle(pre, post, tmo);
      check({tag, " busy after arm"}, bus.busy, 1);
      i   = 0;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < max_cycles) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         v = v && (i < NS);
         bus.valid = v;
         if (v) begin
            bus.dataIn = data_s[i];
            bus.trig   = trig_s[i];
            i++;
         end else begin
            bus.dataIn = SW'($urandom);
            if (mode == 2) bus.trig = 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         cyc++;
      end
      n_exp = (k < 0) ? i : k + post_eff;
      // Trailing cycles: no further writes may appear once done (or, with no
      // trigger, while valid is low).
      for (int j = 0; j < 3; j++) begin
         bus.valid  = (k >= 0);
         bus.trig   = 1'($urandom_range(0, 1));
         bus.dataIn = SW'($urandom);
         @(negedge clock);
      end
      bus.valid = 1'b0;
      check({tag, " write count"}, got_q.size(), n_exp);
      for (int j = 0; j < got_q.size() && j < n_exp; j++)
         check($sformatf("%s write %0d", tag, j), got_q[j], ((j % DEPTH) << 8) | int'(data_s[j]));
      if (k >= 0) begin
         check({tag, " done"},       bus.done,       1);
         check({tag, " busy"},       bus.busy,       0);
         check({tag, " trig_addr"},  bus.trig_addr,  k % DEPTH);
         check({tag, " start_addr"}, bus.start_addr, (k - pre_eff) % DEPTH);
         check({tag, " timed_out"},  bus.timed_out,  by_to);
      end else begin
         check({tag, " done"},      bus.done,      0);
         check({tag, " busy"},      bus.busy,      1);
         check({tag, " timed_out"}, bus.timed_out, 0);
         bus.abort = 1'b1;
         @(negedge clock);
         bus.abort = 1'b0;
         check({tag, " busy after abort"}, bus.busy, 0);
      end
   endtask

   task automatic fill_trig(input int rise_at);
      for (int j = 0; j < NS; j++) trig_s[j] = (rise_at >= 0) && (j >= rise_at);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("reset");

      // Basic window: trigger on the 6th WAIT sample.
      fill_trig(3 + 5);
      run_capture("basic", 3, 4, 0, 0, 100);

      // No pre window, minimum post: single write.
      fill_trig(0);
      run_capture("pre0post0", 0, 0, 0, 0, 50);

      // Pre clipped to DEPTH-post, long WAIT wraps the address.
      fill_trig(30);
      run_capture("wrap", 14, 6, 0, 0, 100);

      // trig high through PRE is ignored; only the WAIT edge triggers.
      fill_trig(7);
      for (int j = 0; j < 4; j++) trig_s[j] = 1'b1;
      run_capture("toggle", 4, 3, 0, 1, 200);

      // No trigger: forced trigger with the timeout option, endless WAIT without.
      fill_trig(-1);
      run_capture("timeout5", 2, 3, 5, 0, 40);
      fill_trig(-1);
      run_capture("timeout0", 2, 3, 0, 0, 40);

      // Abort mid-POST, arm+abort together, reset during PRE.
      fill_trig(4);
      arm_cycle(2, 8, 0);
      for (int j = 0; j < 7; j++) begin
         bus.valid  = 1'b1;
         bus.trig   = trig_s[j];
         bus.dataIn = SW'($urandom);
         @(negedge clock);
      end
      check("abort pre busy", bus.busy, 1);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      check("abort busy",   bus.busy,   0);
      check("abort done",   bus.done,   0);
      check("abort mem_we", bus.mem_we, 0);
      bus.abort = 1'b1;
      arm_cycle(3, 4, 0);
      bus.abort = 1'b0;
      check("arm+abort busy",   bus.busy,   1);
      check("arm+abort mem_we", bus.mem_we, 0);
      bus.dataIn = 8'h5a;
      @(negedge clock);
      check("restart mem_we",   bus.mem_we,   1);
      check("restart mem_addr", bus.mem_addr, 0);
      check("restart mem_data", bus.mem_data, 8'h5a);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.valid = 1'b0;
      check_reset_outputs("mid reset");
      @(negedge clock);
      check("post reset busy", bus.busy, 0);

      // Randomized captures; a forced late edge guarantees completion.
      for (int r = 0; r < 10; r++) begin
         for (int j = 0; j < NS; j++) trig_s[j] = ($urandom_range(0, 3) == 0);
         trig_s[NS-20] = 1'b0;
         trig_s[NS-19] = 1'b1;
         run_capture($sformatf("rand%0d", r), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                     $urandom_range(0, 25), 2, 600);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_capture_controller
